// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared PC width, vectors and enums for the fetch front end
package mips_pkg;

    localparam int PC_W = 30;

    // Word addresses; byte address = {pc, 2'b00}
    localparam logic [PC_W-1:0] RESET_VEC = 30'h0010_0000;
    localparam logic [PC_W-1:0] EXC_VEC   = 30'h2000_0060;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_e;

    // Ordered so that a larger encoding means a higher priority source
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_EXC    = 2'd3
    } rd_src_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - redirect priority select and pending-redirect register
module pc_redirect_sel
    import mips_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exc,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    input  logic            i_latch,
    input  logic            i_clear,
    output logic            o_cur_valid,
    output logic [PC_W-1:0] o_cur_target,
    output logic            o_any_valid,
    output logic [PC_W-1:0] o_any_target
);

    rd_src_e         cur_src;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;

    // Fixed priority among this cycle's requests; the losers are simply dropped
    always_comb begin
        cur_src = RD_NONE;
        if (i_exc) begin
            cur_src = RD_EXC;
        end else if (i_jump) begin
            cur_src = RD_JUMP;
        end else if (i_branch_taken) begin
            cur_src = RD_BRANCH;
        end
    end

    // Target of the winning source
    always_comb begin
        o_cur_target = '0;
        case (cur_src)
            RD_EXC:    o_cur_target = EXC_VEC;
            RD_JUMP:   o_cur_target = i_jump_target;
            RD_BRANCH: o_cur_target = i_branch_target;
            default:   o_cur_target = '0;
        endcase
    end

    assign o_cur_valid = (cur_src != RD_NONE);

    // Pending redirect: any newer redirect replaces the held one, ack clears it
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (i_clear) begin
            pend_valid_d = 1'b0;
        end else if (i_latch && o_cur_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = o_cur_target;
        end
    end

    // Pending register update with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // A redirect arriving with the ack is newer than the pending one, so it wins
    assign o_any_valid  = o_cur_valid | pend_valid_q;
    assign o_any_target = o_cur_valid ? o_cur_target : pend_target_q;

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - next-PC sequencer and single-outstanding instruction fetch controller
// Optional build macro PC_SEQ_PERF_EN adds saturating fetch/squash/stall counters.
module pc_seq
    import mips_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_exc,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_pc,
    input  logic            i_imem_ack,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_squash_cnt,
    output logic [31:0]     o_stall_cnt,
`endif
    output logic            o_fetch_valid,
    output logic [PC_W-1:0] o_fetch_pc
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fv_q, fv_d;
    logic [PC_W-1:0] fpc_q, fpc_d;
    logic            latch, clear;
    logic            cur_valid, any_valid;
    logic [PC_W-1:0] cur_target, any_target;

    pc_redirect_sel u_redirect_sel (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_exc           (i_exc),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_latch         (latch),
        .i_clear         (clear),
        .o_cur_valid     (cur_valid),
        .o_cur_target    (cur_target),
        .o_any_valid     (any_valid),
        .o_any_target    (any_target)
    );

    // Next-state, next-PC and fetch-strobe decisions
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fv_d    = 1'b0;
        fpc_d   = fpc_q;
        latch   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            BOOT: begin
                if (cur_valid) begin
                    pc_d = cur_target;
                end
                state_d = i_stall ? STALL : FETCH;
            end
            FETCH: begin
                if (i_imem_ack) begin
                    clear = 1'b1;
                    if (any_valid) begin
                        // Fetched word belongs to the abandoned path: squash it
                        pc_d = any_target;
                    end else begin
                        fv_d  = 1'b1;
                        fpc_d = pc_q;
                        pc_d  = pc_q + PC_W'(1);
                    end
                    state_d = i_stall ? STALL : FETCH;
                end else begin
                    // Address must stay stable until ack, so park the redirect
                    latch = 1'b1;
                end
            end
            STALL: begin
                if (cur_valid) begin
                    pc_d = cur_target;
                end
                if (!i_stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State registers with synchronous reset; an ack during reset is ignored
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            fv_q    <= 1'b0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            fpc_q   <= fpc_d;
        end
    end

    assign o_imem_req    = (state_q == FETCH);
    assign o_pc          = pc_q;
    assign o_fetch_valid = fv_q;
    assign o_fetch_pc    = fpc_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q, stall_cnt_q;
    logic        squash;

    assign squash = (state_q == FETCH) && i_imem_ack && any_valid;

    // Saturating event counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (fv_q && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (squash && (squash_cnt_q != 32'hFFFF_FFFF)) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
            if ((state_q == STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_fetch_cnt  = fetch_cnt_q;
    assign o_squash_cnt = squash_cnt_q;
    assign o_stall_cnt  = stall_cnt_q;
`endif

endmodule
